// File: rtl/out_port_uart_tx.sv
// out_port_uart_tx
//   Captures bytes written by the MCU to port TX_PORT_ID. Each byte goes into a
//   small FIFO and is then sent LSB first as a UART frame on TX (8N1 by default).
//
//   Optional feature (macro UART_TX_PARITY_EN): adds an even-parity bit between
//   the data and stop bits, which makes the frame 8E1.
//
//   Ports:
//     CLK        system clock (posedge)
//     RST        asynchronous active-high reset
//     OUT_PORT   data byte from the MCU, sampled on the push edge only
//     PORT_ID    port address from the MCU
//     IO_STRB    one-cycle write strobe
//     TX         serial line, registered, idles high
//     TX_BUSY    frame on the line or FIFO non-empty
//     FIFO_FULL  FIFO holds FIFO_DEPTH bytes
//     OVERFLOW   sticky: a write was dropped; cleared only by reset
//     STATUS     {5'b0, OVERFLOW, FIFO_FULL, TX_BUSY}
module out_port_uart_tx #(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [7:0]  TX_PORT_ID   = 8'h40
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] OUT_PORT,
    input  logic [7:0] PORT_ID,
    input  logic       IO_STRB,
    output logic       TX,
    output logic       TX_BUSY,
    output logic       FIFO_FULL,
    output logic       OVERFLOW,
    output logic [7:0] STATUS
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
    localparam logic [15:0]   BAUD_END = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
`ifdef UART_TX_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          ovf_q, ovf_d;
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    mem [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
    logic          par_q, par_d;
`endif

    logic push_req, full, bit_end, pop, do_push;

    assign push_req = IO_STRB && (PORT_ID == TX_PORT_ID);
    assign full     = (cnt_q == CNT_FULL);
    assign bit_end  = (baud_q == BAUD_END);
    // A full FIFO still takes a push when the same edge pops, because the slot frees up.
    assign do_push  = push_req && (!full || pop);

    always_comb begin
        state_d = state_q;
        baud_d  = (state_q == S_IDLE || bit_end) ? 16'd0 : baud_q + 16'd1;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                // cnt_q holds the count from before this edge, so a byte pushed on
                // this same edge cannot be popped until the next one.
                if (cnt_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_START;
                    baud_d  = 16'd0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    // Go straight to the next start bit so there is no idle gap.
                    if (cnt_q != '0) begin
                        pop     = 1'b1;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pop) begin
            shift_d = mem[rd_q];
`ifdef UART_TX_PARITY_EN
            par_d   = ^mem[rd_q];
`endif
        end

        rd_d  = pop ? rd_q + PTR_ONE : rd_q;
        wr_d  = do_push ? wr_q + PTR_ONE : wr_q;
        ovf_d = ovf_q | (push_req && full && !pop);
        case ({do_push, pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase

        // TX is registered from the next-state values so the line has no glitches
        // and changes on the same edge as the state.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = par_d;
`endif
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE) || (cnt_d != '0);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // The storage needs no reset. The pointers and the count decide which entries are valid.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_q] <= OUT_PORT;
    end

    assign TX        = tx_q;
    assign TX_BUSY   = busy_q;
    assign FIFO_FULL = full;
    assign OVERFLOW  = ovf_q;
    assign STATUS    = {5'b0, ovf_q, full, busy_q};
endmodule
